pc_sequencer: RTL and testbench

- Parametrised program-counter block for the fetch stage; successor to the fixed 16-bit bit-cell PC register.
- Holds the PC and advances it by a fixed step each cycle. Supports stall/hold, branch redirect with capture during a stall, and a circular return-address stack for call/return.
- Two gated read ports feed fetch and the branch/link logic.

---
 rtl/pc_sequencer_if.sv | 35 +++
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control and read bus of the fetch-stage PC sequencer.
// The master drives the control inputs and reads the PC/status outputs.
// The slave is the sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             call;
    logic             ret;
    logic             rd_en1;
    logic             rd_en2;
    logic [WIDTH-1:0] rd_data1;
    logic [WIDTH-1:0] rd_data2;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_seq;
    logic             pending;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_underflow;
    logic             misalign;

    modport master (
        output stall, redirect_valid, redirect_target, call, ret, rd_en1, rd_en2,
        input  rd_data1, rd_data2, pc, pc_seq, pending, ras_empty, ras_full,
               ras_underflow, misalign
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, call, ret, rd_en1, rd_en2,
        output rd_data1, rd_data2, pc, pc_seq, pending, ras_empty, ras_full,
               ras_underflow, misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage program counter with stall, stall-time redirect capture
// and a circular return-address stack.
// Define PC_ALIGN_CHECK_EN to force redirect targets to even addresses and flag misalignment.
module pc_sequencer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               STEP      = 2,
    parameter int               RAS_DEPTH = 4
) (
    input logic           clk_i,
    input logic           rst_ni,
    pc_sequencer_if.slave bus
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] pc_q, pc_d, ptgt_q, ptgt_d, pc_seq, tgt;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d, top;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             pend_q, pend_d, unf_q, unf_d, mis_q, mis_d, odd, full;

`ifdef PC_ALIGN_CHECK_EN
    assign tgt = {bus.redirect_target[WIDTH-1:1], 1'b0};
    assign odd = bus.redirect_target[0];
`else
    assign tgt = bus.redirect_target;
    assign odd = 1'b0;
`endif

    // ptr_q is the next free slot, so the top of stack sits just below it.
    assign pc_seq = pc_q + WIDTH'(STEP);
    assign top    = ptr_q - 1'b1;
    assign full   = cnt_q == CW'(RAS_DEPTH);

    assign bus.pc            = pc_q;
    assign bus.pc_seq        = pc_seq;
    assign bus.rd_data1      = bus.rd_en1 ? pc_q : '0;
    assign bus.rd_data2      = bus.rd_en2 ? pc_q : '0;
    assign bus.pending       = pend_q;
    assign bus.ras_empty     = cnt_q == '0;
    assign bus.ras_full      = full;
    assign bus.ras_underflow = unf_q;
    assign bus.misalign      = mis_q;

    // Next PC, pending capture and stack update, highest-priority source first.
    always_comb begin
        pc_d   = pc_q;
        ptgt_d = ptgt_q;
        pend_d = pend_q;
        ras_d  = ras_q;
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        unf_d  = unf_q;
        mis_d  = mis_q | (bus.redirect_valid & odd);
        if (bus.stall) begin
            if (bus.redirect_valid) begin
                pend_d = 1'b1;
                ptgt_d = tgt;
            end
        end else if (bus.redirect_valid) begin
            pc_d   = tgt;
            pend_d = 1'b0;
            if (bus.call) begin
                if (bus.ret && cnt_q != '0) begin
                    ras_d[top] = pc_seq;
                end else begin
                    ras_d[ptr_q] = pc_seq;
                    ptr_d        = ptr_q + 1'b1;
                    cnt_d        = full ? cnt_q : cnt_q + 1'b1;
                end
            end
        end else if (pend_q) begin
            pc_d   = ptgt_q;
            pend_d = 1'b0;
        end else if (bus.ret) begin
            if (cnt_q == '0) begin
                pc_d  = pc_seq;
                unf_d = 1'b1;
            end else begin
                pc_d  = ras_q[top];
                ptr_d = top;
                cnt_d = cnt_q - 1'b1;
            end
        end else begin
            pc_d = pc_seq;
        end
    end

    // State registers; reset clears everything including stack contents and pending redirect.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q   <= RESET_VEC;
            ptgt_q <= '0;
            pend_q <= 1'b0;
            ras_q  <= '{default: '0};
            ptr_q  <= '0;
            cnt_q  <= '0;
            unf_q  <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            ptgt_q <= ptgt_d;
            pend_q <= pend_d;
            ras_q  <= ras_d;
            ptr_q  <= ptr_d;
            cnt_q  <= cnt_d;
            unf_q  <= unf_d;
            mis_q  <= mis_d;
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed vectors for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [15:0] exp_pc;
    logic [15:0] stk [5];

    pc_sequencer_if #(.WIDTH(16)) bus ();

    pc_sequencer #(.WIDTH(16), .RESET_VEC(16'h0000), .STEP(2), .RAS_DEPTH(4)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic s, input logic rv, input logic [15:0] t,
                         input logic c, input logic r);
        bus.stall           = s;
        bus.redirect_valid  = rv;
        bus.redirect_target = t;
        bus.call            = c;
        bus.ret             = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 16'h0, 0, 0);
        bus.rd_en1 = 1'b1;
        bus.rd_en2 = 1'b0;
        #12;
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_pending", bus.pending, 1'b0);
        check("rst_empty", bus.ras_empty, 1'b1);
        check("rst_full", bus.ras_full, 1'b0);
        check("rst_unf", bus.ras_underflow, 1'b0);
        check("rst_mis", bus.misalign, 1'b0);
        rst_n = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("free_pc", bus.pc, 16'(2 * i));
            check("free_rd1", bus.rd_data1, 16'(2 * i));
            check("free_rd2", bus.rd_data2, 16'h0000);
        end
        check("pc_seq", bus.pc_seq, 16'h000A);

        drive(0, 1, 16'h0010, 0, 0);
        step();
        check("redir_pc", bus.pc, 16'h0010);
        drive(1, 0, 16'h0, 0, 0);
        step();
        check("stall1_pc", bus.pc, 16'h0010);
        drive(1, 1, 16'h0040, 0, 0);
        step();
        check("stall2_pc", bus.pc, 16'h0010);
        check("stall2_pend", bus.pending, 1'b1);
        drive(1, 0, 16'h0, 0, 0);
        step();
        check("stall3_pc", bus.pc, 16'h0010);
        check("stall3_pend", bus.pending, 1'b1);
        drive(0, 0, 16'h0, 0, 0);
        step();
        check("release_pc", bus.pc, 16'h0040);
        check("release_pend", bus.pending, 1'b0);
        step();
        check("after_rel_pc", bus.pc, 16'h0042);

        drive(0, 1, 16'h0100, 0, 0);
        step();
        drive(0, 1, 16'h0200, 1, 0);
        step();
        check("call_pc", bus.pc, 16'h0200);
        check("call_nonempty", bus.ras_empty, 1'b0);
        drive(0, 0, 16'h0, 0, 1);
        step();
        check("ret_pc", bus.pc, 16'h0102);
        check("ret_empty", bus.ras_empty, 1'b1);

        exp_pc = 16'h0102;
        for (int i = 0; i < 5; i++) begin
            stk[i] = exp_pc + 16'h2;
            exp_pc = 16'h1000 + 16'(i * 16'h100);
            drive(0, 1, exp_pc, 1, 0);
            step();
            check("nest_pc", bus.pc, exp_pc);
        end
        check("nest_full", bus.ras_full, 1'b1);
        drive(0, 0, 16'h0, 0, 1);
        for (int k = 4; k >= 1; k--) begin
            step();
            check("pop_pc", bus.pc, stk[k]);
        end
        check("pop_empty", bus.ras_empty, 1'b1);
        check("pop_unf0", bus.ras_underflow, 1'b0);
        step();
        check("unf_pc", bus.pc, 16'h1004);
        check("unf_flag", bus.ras_underflow, 1'b1);

        drive(0, 1, 16'h2000, 1, 0);
        step();
        drive(0, 1, 16'h3000, 1, 1);
        step();
        check("callret_pc", bus.pc, 16'h3000);
        drive(0, 0, 16'h0, 0, 1);
        step();
        check("callret_pop", bus.pc, 16'h2002);
        check("callret_empty", bus.ras_empty, 1'b1);

        drive(0, 1, 16'hFFFE, 0, 0);
        step();
        drive(0, 0, 16'h0, 0, 0);
        step();
        check("wrap_pc", bus.pc, 16'h0000);

        drive(1, 1, 16'h0500, 0, 0);
        step();
        drive(0, 1, 16'h0600, 0, 0);
        step();
        check("newredir_pc", bus.pc, 16'h0600);
        check("newredir_pend", bus.pending, 1'b0);

        drive(0, 1, 16'h0033, 0, 0);
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc", bus.pc, 16'h0032);
        check("align_flag", bus.misalign, 1'b1);
`else
        check("align_pc", bus.pc, 16'h0033);
        check("align_flag", bus.misalign, 1'b0);
`endif

        drive(0, 1, 16'h0700, 1, 0);
        step();
        drive(1, 1, 16'h0800, 0, 0);
        step();
        check("pre_rst_pend", bus.pending, 1'b1);
        check("pre_rst_empty", bus.ras_empty, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", bus.pc, 16'h0000);
        check("async_pend", bus.pending, 1'b0);
        check("async_empty", bus.ras_empty, 1'b1);
        check("async_unf", bus.ras_underflow, 1'b0);
        check("async_mis", bus.misalign, 1'b0);
        drive(0, 0, 16'h0, 0, 0);
        #3;
        rst_n = 1'b1;
        step();
        check("post_rst_pc", bus.pc, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
